// File: rtl/lbist_sequencer.sv
// LBIST run controller: seeds the TPG, applies N patterns, drains the CUT pipeline,
// then compares the ORA signature against a golden value.
module lbist_sequencer #(
    parameter int PAT_BITS = 16,
    parameter int SIG_BITS = 32,
    parameter int CUT_LAT  = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [PAT_BITS-1:0] i_num_patterns,
    input  logic [SIG_BITS-1:0] i_golden,
    input  logic [SIG_BITS-1:0] i_signature,
    output logic                o_test_mode,
    output logic                o_tpg_seed,
    output logic                o_tpg_en,
    output logic                o_ora_clr,
    output logic                o_ora_en,
    output logic [PAT_BITS-1:0] o_pattern_cnt,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_pass
);

    // state   | meaning
    // IDLE    | waiting for start, datapath untouched
    // INIT    | seed LFSR, clear ORA, clear pattern count and delay line
    // RUN     | one pattern per cycle until N applied
    // FLUSH   | CUT_LAT cycles draining the CUT pipeline into the ORA
    // COMPARE | register signature == golden
    // DONE    | result valid, waiting for the next start
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_RUN     = 3'd2,
        S_FLUSH   = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [PAT_BITS-1:0] CNT_ONE    = PAT_BITS'(1);
    localparam int unsigned         FLUSH_INIT = (CUT_LAT > 0) ? CUT_LAT - 1 : 0;
    localparam logic [3:0]          FLUSH_LOAD = 4'(FLUSH_INIT);

    state_t              r_state;
    state_t              w_next;
    logic [PAT_BITS-1:0] r_n;
    logic [PAT_BITS-1:0] r_cnt;
    logic [3:0]          r_flush;
    logic                r_pass;

    logic w_latch_n;
    logic w_cnt_clr;
    logic w_cnt_inc;
    logic w_flush_load;
    logic w_flush_dec;
    logic w_pass_load;
    logic w_pass_clr;
    logic w_dly_clr;
    logic w_tpg_en;
    logic w_last_pat;

    assign w_last_pat = (r_cnt == (r_n - CNT_ONE));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_latch_n    = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_flush_load = 1'b0;
        w_flush_dec  = 1'b0;
        w_pass_load  = 1'b0;
        w_pass_clr   = 1'b0;
        w_dly_clr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    w_next    = S_INIT;
                    w_latch_n = 1'b1;
                end
            end
            S_INIT: begin
                if (i_abort) begin
                    w_next     = S_IDLE;
                    w_pass_clr = 1'b1;
                    w_dly_clr  = 1'b1;
                end else begin
                    w_cnt_clr = 1'b1;
                    w_dly_clr = 1'b1;
                    w_next    = (r_n == '0) ? S_COMPARE : S_RUN;
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    w_next     = S_IDLE;
                    w_pass_clr = 1'b1;
                    w_dly_clr  = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                    if (w_last_pat) begin
                        w_next       = (CUT_LAT == 0) ? S_COMPARE : S_FLUSH;
                        w_flush_load = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (i_abort) begin
                    w_next     = S_IDLE;
                    w_pass_clr = 1'b1;
                    w_dly_clr  = 1'b1;
                end else if (r_flush == 4'd0) begin
                    w_next = S_COMPARE;
                end else begin
                    w_flush_dec = 1'b1;
                end
            end
            S_COMPARE: begin
                if (i_abort) begin
                    w_next     = S_IDLE;
                    w_pass_clr = 1'b1;
                    w_dly_clr  = 1'b1;
                end else begin
                    w_pass_load = 1'b1;
                    w_next      = S_DONE;
                end
            end
            S_DONE: begin
                // abort here only serves to block a simultaneous start
                if (i_start && !i_abort) begin
                    w_next     = S_INIT;
                    w_latch_n  = 1'b1;
                    w_pass_clr = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_n     <= '0;
            r_cnt   <= '0;
            r_flush <= 4'd0;
            r_pass  <= 1'b0;
        end else begin
            if (w_latch_n) begin
                r_n <= i_num_patterns;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
            if (w_flush_load) begin
                r_flush <= FLUSH_LOAD;
            end else if (w_flush_dec) begin
                r_flush <= r_flush - 4'd1;
            end
            if (w_pass_clr) begin
                r_pass <= 1'b0;
            end else if (w_pass_load) begin
                r_pass <= (i_signature == i_golden);
            end
        end
    end

    assign w_tpg_en      = (r_state == S_RUN);
    assign o_busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_test_mode   = o_busy;
    assign o_tpg_seed    = (r_state == S_INIT);
    assign o_ora_clr     = (r_state == S_INIT);
    assign o_tpg_en      = w_tpg_en;
    assign o_done        = (r_state == S_DONE);
    assign o_pass        = r_pass;
    assign o_pattern_cnt = r_cnt;

    // ora_en tracks tpg_en through a shift register matching the CUT latency
    generate
        if (CUT_LAT == 0) begin : g_no_dly
            assign o_ora_en = w_tpg_en;
        end else begin : g_dly
            logic [CUT_LAT-1:0] r_dly;
            always_ff @(posedge i_clk) begin
                if (i_rst || w_dly_clr) begin
                    r_dly <= '0;
                end else begin
                    r_dly[0] <= w_tpg_en;
                    for (int i = 1; i < CUT_LAT; i++) begin
                        r_dly[i] <= r_dly[i-1];
                    end
                end
            end
            assign o_ora_en = r_dly[CUT_LAT-1];
        end
    endgenerate

endmodule
